psion_fb_arbiter: RTL

Single-port framebuffer RAM arbiter between the Psion LCD scan-out reader and the host byte-stream writer (UART today, SPI later). Display reads have strict priority and fixed latency. Host writes are auto-addressed by a raster cursor, buffered in a small FIFO, and retired in idle RAM cycles. It sits between the framebuffer block RAM and both the LCD driver and the host receiver, and replaces the RAM's ad-hoc dual access.

---
 rtl/psion_fb_pkg.sv | 23 ++
 rtl/fb_write_fifo.sv | 53 +++++
 rtl/psion_fb_arbiter.sv | 110 +++++++++++
 3 files changed

// File: rtl/psion_fb_pkg.sv
// Shared framebuffer geometry, write-entry type and address helper
// for the Psion LCD framebuffer arbiter.
package psion_fb_pkg;

  localparam int FB_COLS   = 64;
  localparam int FB_ROWS   = 240;
  localparam int FB_ADDR_W = 14;
  localparam int X_W       = 6;
  localparam int Y_W       = FB_ADDR_W - X_W;

  typedef struct packed {
    logic [FB_ADDR_W-1:0] addr;
    logic [7:0]           data;
  } fb_wr_t;

  function automatic logic [FB_ADDR_W-1:0] fb_addr(
    input logic [X_W-1:0] x,
    input logic [Y_W-1:0] y
  );
    return {y, x};
  endfunction

endpackage

// File: rtl/fb_write_fifo.sv
// Synchronous write FIFO of framebuffer entries with a
// first-word-fall-through head; pushes and pops are self-guarding.
module fb_write_fifo
  import psion_fb_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  fb_wr_t           push_data,
  input  logic             pop,
  output fb_wr_t           head,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  fb_wr_t           mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      if (do_push && !do_pop)
        count <= count + 1'b1;
      else if (do_pop && !do_push)
        count <= count - 1'b1;
    end
  end

  // Storage needs no reset; occupancy is tracked by count alone.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= push_data;
  end

endmodule

// File: rtl/psion_fb_arbiter.sv
// Single-port framebuffer arbiter: LCD reads win, host bytes are
// raster-addressed, queued, and written in idle RAM cycles.
module psion_fb_arbiter
  import psion_fb_pkg::*;
#(
  parameter  int COLS       = FB_COLS,
  parameter  int ROWS       = FB_ROWS,
  parameter  int ADDR_W     = FB_ADDR_W,
  parameter  int FIFO_DEPTH = 4,
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic              rd_valid,
  input  logic              wr_valid,
  input  logic [7:0]        wr_data,
  output logic              wr_ready,
  input  logic              wr_home,
  output logic              frame_done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata
);

  logic [X_W-1:0]   cur_x;
  logic [Y_W-1:0]   cur_y;
  logic             x_last;
  logic             y_last;
  logic             accept;
  logic             pop;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  fb_wr_t           push_data;
  fb_wr_t           head;
  logic [1:0]       rd_pipe;

  assign wr_ready = !reset && (fifo_count < CNT_W'(FIFO_DEPTH));
  assign accept   = wr_valid && wr_ready;
  assign x_last   = (cur_x == X_W'(COLS - 1));
  assign y_last   = (cur_y == Y_W'(ROWS - 1));
  assign pop      = !rd_req && !fifo_empty;

  assign push_data.addr = wr_home ? '0 : fb_addr(cur_x, cur_y);
  assign push_data.data = wr_data;

  fb_write_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (accept),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // A homed byte takes address 0, so the cursor resumes at (1,0).
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_x      <= '0;
      cur_y      <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= accept && !wr_home && x_last && y_last;
      if (wr_home) begin
        cur_x <= accept ? X_W'(1) : '0;
        cur_y <= '0;
      end else if (accept) begin
        if (x_last) begin
          cur_x <= '0;
          cur_y <= y_last ? '0 : cur_y + 1'b1;
        end else begin
          cur_x <= cur_x + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ram_addr  <= '0;
      ram_we    <= 1'b0;
      ram_wdata <= '0;
      rd_pipe   <= '0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
    end else begin
      rd_pipe  <= {rd_pipe[0], rd_req};
      rd_valid <= rd_pipe[1];
      if (rd_pipe[1]) rd_data <= ram_rdata;
      if (rd_req) begin
        ram_addr <= rd_addr;
        ram_we   <= 1'b0;
      end else if (!fifo_empty) begin
        ram_addr  <= head.addr;
        ram_wdata <= head.data;
        ram_we    <= 1'b1;
      end else begin
        ram_we <= 1'b0;
      end
    end
  end

endmodule
